fetch_unit: RTL and testbench

Sequential instruction-fetch and next-PC block for the single-cycle MIPS core. It sits at the other end of the control decoder's PC-steering interface (is_jump, zero_branch, need_zero, status_branch, need_st_Z, pc_select).
- Owns the PC register and the status Z flag.
- Fetches each instruction from instruction memory over a req/ack handshake and presents it to the decoder for one EXEC cycle.
- Resolves the branch/jump decision from the decoder outputs and updates the PC.

---
 rtl/fetch_unit_pkg.sv | 15 +
 rtl/fetch_unit_next_pc_calc.sv | 38 +++
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared PC-select codes and FSM state encoding for the fetch unit
package fetch_unit_pkg;

    localparam logic [1:0] PCSEL_OFFSET = 2'b00;
    localparam logic [1:0] PCSEL_TARGET = 2'b01;
    localparam logic [1:0] PCSEL_REG    = 2'b10;
    localparam logic [1:0] PCSEL_MEM    = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10
    } state_t;

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// rtl/fetch_unit_next_pc_calc.sv - combinational branch decision and redirect target mux
module next_pc_calc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] imm26,
    input  logic        is_jump,
    input  logic        zero_branch,
    input  logic        need_zero,
    input  logic        status_branch,
    input  logic        need_st_Z,
    input  logic [1:0]  pc_select,
    input  logic        alu_zero,
    input  logic        status_z,
    input  logic [31:0] reg_target,
    input  logic [31:0] mem_target,
    output logic        taken,
    output logic [31:0] seq,
    output logic [31:0] target
);

    assign seq   = pc + 32'd4;
    assign taken = is_jump
                 | (zero_branch   & (alu_zero == need_zero))
                 | (status_branch & (status_z == need_st_Z));

    // Redirect target; register and memory targets are word-aligned by masking the low bits
    always_comb begin
        target = seq;
        unique case (pc_select)
            PCSEL_OFFSET: target = seq + {{14{imm26[15]}}, imm26[15:0], 2'b00};
            PCSEL_TARGET: target = {seq[31:28], imm26, 2'b00};
            PCSEL_REG:    target = reg_target & 32'hFFFF_FFFC;
            PCSEL_MEM:    target = mem_target & 32'hFFFF_FFFC;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register, status Z flag and IDLE/FETCH/EXEC fetch FSM (option: DELAY_SLOT_EN)
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instruction,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link_addr,
    input  logic              is_jump,
    input  logic              zero_branch,
    input  logic              need_zero,
    input  logic              status_branch,
    input  logic              need_st_Z,
    input  logic [1:0]        pc_select,
    input  logic              alu_zero,
    input  logic [31:0]       reg_target,
    input  logic [31:0]       mem_target,
    input  logic              status_we,
    input  logic              status_z_in,
    input  logic              exec_stall,
    output logic              status_z
);

    state_t      state;
    state_t      state_nxt;
    logic        taken;
    logic [31:0] seq;
    logic [31:0] target;
    logic [31:0] pc_update;
    logic        exec_done;

    next_pc_calc u_next_pc_calc (
        .pc            (pc),
        .imm26         (instruction[25:0]),
        .is_jump       (is_jump),
        .zero_branch   (zero_branch),
        .need_zero     (need_zero),
        .status_branch (status_branch),
        .need_st_Z     (need_st_Z),
        .pc_select     (pc_select),
        .alu_zero      (alu_zero),
        .status_z      (status_z),
        .reg_target    (reg_target),
        .mem_target    (mem_target),
        .taken         (taken),
        .seq           (seq),
        .target        (target)
    );

    assign exec_done = (state == EXEC) && !exec_stall;
    assign imem_addr = pc;

`ifdef DELAY_SLOT_EN
    logic        pending_valid;
    logic [31:0] pending_target;

    // The delay-slot instruction always falls through; a branch inside it is ignored
    assign pc_update = pending_valid ? pending_target : seq;
    assign link_addr = pc + 32'd8;

    // Capture a taken redirect so it lands after the delay slot; reset drops it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_valid  <= 1'b0;
            pending_target <= '0;
        end else if (exec_done) begin
            pending_valid  <= !pending_valid && taken;
            pending_target <= target;
        end
    end
`else
    assign pc_update = taken ? target : seq;
    assign link_addr = seq;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        unique case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (!exec_stall) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Instruction latch, PC and Z flag; branch evaluation sees the Z value before this write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            instruction <= '0;
            status_z    <= 1'b0;
        end else begin
            if ((state == FETCH) && imem_ack) begin
                instruction <= imem_rdata;
            end
            if (exec_done) begin
                pc <= pc_update;
                if (status_we) begin
                    status_z <= status_z_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed table-driven bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        is_jump, zero_branch, need_zero, status_branch, need_st_Z;
    logic [1:0]  pc_select;
    logic        alu_zero;
    logic [31:0] reg_target, mem_target;
    logic        status_we, status_z_in, exec_stall;
    logic        status_z;

`ifdef DELAY_SLOT_EN
    localparam logic [31:0] LINK_OFF = 32'd8;
`else
    localparam logic [31:0] LINK_OFF = 32'd4;
`endif

    fetch_unit #(.RESET_PC(32'h0), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instruction(instruction), .instr_valid(instr_valid), .pc(pc), .link_addr(link_addr),
        .is_jump(is_jump), .zero_branch(zero_branch), .need_zero(need_zero),
        .status_branch(status_branch), .need_st_Z(need_st_Z), .pc_select(pc_select),
        .alu_zero(alu_zero), .reg_target(reg_target), .mem_target(mem_target),
        .status_we(status_we), .status_z_in(status_z_in), .exec_stall(exec_stall),
        .status_z(status_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] instr;
        logic        j, zb, nz, sb, nsz;
        logic [1:0]  sel;
        logic        az;
        logic [31:0] rt, mt;
        logic        we, zin;
        int          stall, lat;
        logic [31:0] pc, nxt;
        logic        z;
    } vec_t;

    vec_t tbl[$];
    int   tests = 0;
    int   fails = 0;
    logic prev_z;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic j, zb, nz, sb, nsz,
                                input logic [1:0] sel, input logic az,
                                input logic [31:0] rt, mt, input logic we, zin,
                                input int stall, lat, input logic [31:0] vpc, nxt,
                                input logic z);
        vec_t v;
        v.instr = instr; v.j = j; v.zb = zb; v.nz = nz; v.sb = sb; v.nsz = nsz;
        v.sel = sel; v.az = az; v.rt = rt; v.mt = mt; v.we = we; v.zin = zin;
        v.stall = stall; v.lat = lat; v.pc = vpc; v.nxt = nxt; v.z = z;
        return v;
    endfunction

    task automatic clear_dec();
        is_jump = 0; zero_branch = 0; need_zero = 0; status_branch = 0; need_st_Z = 0;
        pc_select = 2'b00; alu_zero = 0; reg_target = 0; mem_target = 0;
        status_we = 0; status_z_in = 0; exec_stall = 0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n = 0;
        string t;
        t = $sformatf("v%0d", idx);
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({t, "_req"}, {31'd0, imem_req}, 32'd1);
        check({t, "_fetch_addr"}, imem_addr, v.pc);
        for (int k = 0; k < v.lat; k++) begin
            @(negedge clk);
            check({t, "_req_held"}, {31'd0, imem_req}, 32'd1);
        end
        imem_ack = 1; imem_rdata = v.instr;
        is_jump = v.j; zero_branch = v.zb; need_zero = v.nz; status_branch = v.sb;
        need_st_Z = v.nsz; pc_select = v.sel; alu_zero = v.az; reg_target = v.rt;
        mem_target = v.mt; status_we = v.we; status_z_in = v.zin; exec_stall = 0;
        @(negedge clk);
        imem_ack = 0; imem_rdata = 32'hBAD0_BAD0;
        check({t, "_valid"}, {31'd0, instr_valid}, 32'd1);
        check({t, "_instr"}, instruction, v.instr);
        check({t, "_pc"}, pc, v.pc);
        check({t, "_link"}, link_addr, v.pc + LINK_OFF);
        for (int k = 0; k < v.stall; k++) begin
            exec_stall = 1;
            @(negedge clk);
            check({t, "_stall_valid"}, {31'd0, instr_valid}, 32'd1);
            check({t, "_stall_pc"}, pc, v.pc);
            check({t, "_stall_z"}, {31'd0, status_z}, {31'd0, prev_z});
        end
        exec_stall = 0;
        @(negedge clk);
        clear_dec();
        check({t, "_valid_drop"}, {31'd0, instr_valid}, 32'd0);
        check({t, "_next_addr"}, imem_addr, v.nxt);
        check({t, "_z"}, {31'd0, status_z}, {31'd0, v.z});
        prev_z = v.z;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t post;
        rst_n = 0; imem_ack = 0; imem_rdata = 0; prev_z = 0;
        clear_dec();

`ifdef DELAY_SLOT_EN
        tbl.push_back(mk(32'h2010FEFE, 0,0,0,0,0, 2'b00, 0, 0, 0, 0,0, 0,0, 32'h0,   32'h4,   0));
        tbl.push_back(mk(32'h00000008, 1,0,0,0,0, 2'b10, 0, 32'h100, 0, 0,0, 0,0, 32'h4,   32'h8,   0));
        tbl.push_back(mk(32'h08000004, 1,0,0,0,0, 2'b01, 0, 0, 0, 0,0, 0,0, 32'h8,   32'h100, 0));
        tbl.push_back(mk(32'h2010FEFE, 0,0,0,0,0, 2'b00, 0, 0, 0, 0,0, 0,0, 32'h100, 32'h104, 0));
        tbl.push_back(mk(32'h154BFFFC, 0,1,0,0,0, 2'b00, 0, 0, 0, 0,0, 0,0, 32'h104, 32'h108, 0));
        tbl.push_back(mk(32'h2010FEFE, 0,0,0,0,0, 2'b00, 0, 0, 0, 0,0, 0,0, 32'h108, 32'h0F8, 0));
        tbl.push_back(mk(32'h00000008, 1,0,0,0,0, 2'b10, 0, 32'h200, 0, 0,0, 0,0, 32'h0F8, 32'h0FC, 0));
`else
        tbl.push_back(mk(32'h2010FEFE, 0,0,0,0,0, 2'b00, 0, 0, 0, 0,0, 0,0, 32'h0,   32'h4,   0));
        tbl.push_back(mk(32'h00000008, 1,0,0,0,0, 2'b10, 0, 32'h100, 0, 0,0, 0,0, 32'h4,   32'h100, 0));
        tbl.push_back(mk(32'h08000004, 1,0,0,0,0, 2'b01, 0, 0, 0, 0,0, 0,0, 32'h100, 32'h010, 0));
        tbl.push_back(mk(32'h00000008, 1,0,0,0,0, 2'b10, 0, 32'h100, 0, 0,0, 0,0, 32'h010, 32'h100, 0));
        tbl.push_back(mk(32'h154BFFFC, 0,1,0,0,0, 2'b00, 0, 0, 0, 0,0, 0,0, 32'h100, 32'h0F4, 0));
        tbl.push_back(mk(32'h00000008, 1,0,0,0,0, 2'b10, 0, 32'h100, 0, 0,0, 0,0, 32'h0F4, 32'h100, 0));
        tbl.push_back(mk(32'h154BFFFC, 0,1,0,0,0, 2'b00, 1, 0, 0, 0,0, 0,0, 32'h100, 32'h104, 0));
        tbl.push_back(mk(32'h10000010, 0,0,0,1,1, 2'b00, 0, 0, 0, 1,1, 0,0, 32'h104, 32'h108, 1));
        tbl.push_back(mk(32'h10000010, 0,0,0,1,1, 2'b00, 0, 0, 0, 0,0, 0,0, 32'h108, 32'h14C, 1));
        tbl.push_back(mk(32'h00000008, 1,0,0,0,0, 2'b10, 0, 32'h2003, 0, 1,0, 3,2, 32'h14C, 32'h2000, 0));
        tbl.push_back(mk(32'h8C000000, 1,0,0,0,0, 2'b11, 0, 0, 32'h3007, 1,1, 0,1, 32'h2000, 32'h3004, 1));
        tbl.push_back(mk(32'h1000FFFF, 0,1,1,0,0, 2'b00, 1, 0, 0, 0,0, 0,0, 32'h3004, 32'h3004, 1));
        tbl.push_back(mk(32'h00000008, 1,0,0,0,0, 2'b10, 0, 32'hFFFFFFFC, 0, 1,0, 0,0, 32'h3004, 32'hFFFFFFFC, 0));
        tbl.push_back(mk(32'h2010FEFE, 0,0,0,0,0, 2'b00, 0, 0, 0, 0,0, 0,0, 32'hFFFFFFFC, 32'h0, 0));
        tbl.push_back(mk(32'h08000040, 1,0,0,0,0, 2'b01, 0, 0, 0, 0,0, 0,0, 32'h0,   32'h100, 0));
        tbl.push_back(mk(32'h00000008, 1,0,0,0,0, 2'b10, 0, 32'h200, 0, 0,0, 0,0, 32'h100, 32'h200, 0));
`endif
        post = mk(32'h2010FEFE, 0,0,0,0,0, 2'b00, 0, 0, 0, 0,0, 0,0, 32'h0, 32'h4, 0);

        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_z", {31'd0, status_z}, 32'd0);
        check("rst_instr", instruction, 32'h0);
        rst_n = 1;
        @(negedge clk);
        check("idle_req", {31'd0, imem_req}, 32'd1);

        foreach (tbl[i]) run_vec(i, tbl[i]);

        // Reset with an ack landing in the same cycle; the fetch must be abandoned
        check("pre_rst_req", {31'd0, imem_req}, 32'd1);
        rst_n = 0; imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("mid_rst_req", {31'd0, imem_req}, 32'd0);
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_instr", instruction, 32'h0);
        @(negedge clk);
        check("mid_rst_hold_instr", instruction, 32'h0);
        check("mid_rst_hold_valid", {31'd0, instr_valid}, 32'd0);
        rst_n = 1; imem_ack = 0;
        prev_z = 0;
        check("post_rst_idle", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        run_vec(99, post);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
